// File: rtl/lcd_seq_pkg.sv
// lcd_seq_pkg: state type and per-state output decode shared by the LCD power sequencer
package lcd_seq_pkg;
  typedef enum logic [2:0] {S_OFF, S_RST, S_WAKE, S_SETTLE, S_ON, S_DRAIN} lcd_seq_state_t;
  typedef struct packed {
    logic lcd_reset;
    logic drv_resetn;
    logic disp_en;
    logic ready;
  } lcd_seq_out_t;
  localparam lcd_seq_out_t OUT_OFF    = 4'b0000;
  localparam lcd_seq_out_t OUT_RST    = 4'b0000;
  localparam lcd_seq_out_t OUT_WAKE   = 4'b1000;
  localparam lcd_seq_out_t OUT_SETTLE = 4'b1100;
  localparam lcd_seq_out_t OUT_ON     = 4'b1111;
  localparam lcd_seq_out_t OUT_DRAIN  = 4'b1100;
  function automatic lcd_seq_out_t out_decode(input lcd_seq_state_t s);
    return s == S_ON ? OUT_ON : s == S_DRAIN ? OUT_DRAIN : s == S_SETTLE ? OUT_SETTLE :
           s == S_WAKE ? OUT_WAKE : s == S_RST ? OUT_RST : OUT_OFF;
  endfunction
endpackage

// File: rtl/lcd_seq_wdog.sv
// lcd_seq_wdog: counts quiet cycles while armed; timeout when WDOG_CYCLES elapse without a kick
module lcd_seq_wdog #(
  parameter int WDOG_CYCLES = 1000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic arm,
  input  logic kick,
  output logic timeout
);
  localparam int W = $clog2(WDOG_CYCLES);
  localparam logic [W-1:0] LIM = W'(WDOG_CYCLES - 2);
  logic [W-1:0] cnt;
  // restart on every kick and whenever disarmed, so only continuous silence expires
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt <= '0;
    else cnt <= (!arm || kick) ? '0 : cnt + W'(1);
  assign timeout = arm && cnt == LIM;
endmodule

// File: rtl/lcd_power_seq.sv
// lcd_power_seq: LCD panel power-up/down sequencer; define LCD_POWER_SEQ_WDOG_EN to add the vsync watchdog
module lcd_power_seq
  import lcd_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 240,
  parameter int WAKE_CYCLES   = 2400,
  parameter int SETTLE_FRAMES = 2,
  parameter int WDOG_CYCLES   = 1000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic enable,
  input  logic lcd_vsync,
  output logic lcd_reset,
  output logic drv_resetn,
  output logic disp_en,
  output logic ready,
  output logic fault
);
  localparam int MAX_CYC = RST_CYCLES > WAKE_CYCLES ? RST_CYCLES : WAKE_CYCLES;
  localparam int CW = MAX_CYC > 1 ? $clog2(MAX_CYC) : 1;
  lcd_seq_state_t state, nxt;
  lcd_seq_out_t outs;
  logic [CW-1:0] cnt;
  logic [3:0] frames;
  logic vs_d, rise, timeout;
  assign rise = lcd_vsync & ~vs_d;
  assign {lcd_reset, drv_resetn, disp_en, ready} = outs;
`ifdef LCD_POWER_SEQ_WDOG_EN
  lcd_seq_wdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
    .clk(clk),
    .resetn(resetn),
    .arm(state inside {S_SETTLE, S_ON, S_DRAIN}),
    .kick(rise | (nxt != state)),
    .timeout(timeout)
  );
  // fault is a registered copy of the timeout, aligned with the jump to RST
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) fault <= 1'b0;
    else fault <= timeout;
`else
  assign timeout = 1'b0;
  assign fault = 1'b0;
`endif
  // next state: watchdog beats disable, disable beats counter expiry and vsync
  always_comb begin
    nxt = state;
    case (state)
      S_OFF:    if (enable) nxt = S_RST;
      S_RST:    nxt = !enable ? S_OFF : cnt == CW'(RST_CYCLES - 1) ? S_WAKE : S_RST;
      S_WAKE:   nxt = !enable ? S_OFF : cnt == CW'(WAKE_CYCLES - 1) ? S_SETTLE : S_WAKE;
      S_SETTLE: nxt = !enable ? S_OFF : (rise && frames == 4'(SETTLE_FRAMES - 1)) ? S_ON : S_SETTLE;
      S_ON:     if (!enable) nxt = S_DRAIN;
      S_DRAIN:  if (rise) nxt = S_OFF;
      default:  nxt = S_OFF;
    endcase
    if (timeout) nxt = S_RST;
  end
  // state, counters and outputs decoded from the next state so they move together
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state  <= S_OFF;
      cnt    <= '0;
      frames <= '0;
      vs_d   <= 1'b1;
      outs   <= OUT_OFF;
    end else begin
      state  <= nxt;
      cnt    <= nxt != state ? '0 : cnt + CW'(1);
      frames <= (state == S_SETTLE && nxt == S_SETTLE) ? frames + 4'(rise) : '0;
      vs_d   <= lcd_vsync;
      outs   <= out_decode(nxt);
    end
endmodule
